// File: rtl/pool_stream_engine_pkg.sv
// Shared encodings and default geometry for the 2x2 pooling stream engine.
package pool_pkg;
  localparam int POOL_IMG_H = 6;
  localparam int POOL_IMG_W = 6;
  localparam int POOL_CH    = 3;
  localparam int POOL_DW    = 8;

  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;
endpackage

// File: rtl/pool_stream_engine_if.sv
// Frame-level handshake bundle: one whole feature map in, one pooled map out.
interface pool_stream_engine_if
  import pool_pkg::*;
#(
  parameter int IMG_H = POOL_IMG_H,
  parameter int IMG_W = POOL_IMG_W,
  parameter int CH    = POOL_CH,
  parameter int DW    = POOL_DW
);
  localparam int FW = IMG_H*IMG_W*CH*DW;
  localparam int PW = (IMG_H/2)*(IMG_W/2)*CH*DW;

  logic          in_vld;
  logic          in_rdy;
  logic          mode;
  logic [FW-1:0] conv_lin;
  logic [PW-1:0] pool_lin;
  logic          out_vld;
  logic          out_rdy;
  logic          busy;

  modport slave  (input  in_vld, mode, conv_lin, out_rdy,
                  output in_rdy, pool_lin, out_vld, busy);
  modport master (output in_vld, mode, conv_lin, out_rdy,
                  input  in_rdy, pool_lin, out_vld, busy);
endinterface

// File: rtl/pool_win_reduce.sv
// Combinational 2x2 window reducer: max, or floor average when POOL_AVG_EN is defined.
module pool_win_reduce
  import pool_pkg::*;
#(
  parameter int DW = POOL_DW
)(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  input  logic          mode,
  output logic [DW-1:0] y
);
  logic [DW-1:0] m_ab, m_cd, mx;

  assign m_ab = (a > b) ? a : b;
  assign m_cd = (c > d) ? c : d;
  assign mx   = (m_ab > m_cd) ? m_ab : m_cd;

`ifdef POOL_AVG_EN
  // Two guard bits hold the four-term sum, so the shift never loses the carry.
  logic [DW+1:0] sum;
  assign sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  assign y   = (mode == POOL_MODE_AVG) ? sum[DW+1:2] : mx;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign y = mx;
`endif
endmodule

// File: rtl/pool_stream_engine.sv
// Frame-in / frame-out 2x2 stride-2 pooling engine, one window per cycle across all channels.
// Average mode is built only when POOL_AVG_EN is defined.
module pool_stream_engine
  import pool_pkg::*;
#(
  parameter int IMG_H = POOL_IMG_H,
  parameter int IMG_W = POOL_IMG_W,
  parameter int CH    = POOL_CH,
  parameter int DW    = POOL_DW
)(
  input  logic               clk,
  input  logic               rst,
  pool_stream_engine_if.slave bus
);
  localparam int HO   = IMG_H/2;
  localparam int WO   = IMG_W/2;
  localparam int NPIX = IMG_H*IMG_W;
  localparam int NOUT = HO*WO;
  localparam int EW   = $clog2(NPIX);
  localparam int OW   = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int RW   = (HO > 1) ? $clog2(HO) : 1;
  localparam int CW   = (WO > 1) ? $clog2(WO) : 1;

  pool_state_e                     state;
  logic [RW-1:0]                   wr;
  logic [CW-1:0]                   wc;
  logic                            mode_q;
  logic                            out_vld_q;
  logic [CH-1:0][NPIX-1:0][DW-1:0] frame_q;
  logic [CH-1:0][NOUT-1:0][DW-1:0] pool_q;
  logic [CH-1:0][DW-1:0]           win_a, win_b, win_c, win_d, win_y;
  logic [EW-1:0]                   idx_tl;
  logic [OW-1:0]                   idx_out;
  logic                            last_win;

  // Top-left element of the current window; the other three are fixed offsets.
  always_comb begin
    idx_tl  = EW'(2*int'(wr)*IMG_W + 2*int'(wc));
    idx_out = OW'(int'(wr)*WO + int'(wc));
    for (int k = 0; k < CH; k++) begin
      win_a[k] = frame_q[k][idx_tl];
      win_b[k] = frame_q[k][idx_tl + EW'(1)];
      win_c[k] = frame_q[k][idx_tl + EW'(IMG_W)];
      win_d[k] = frame_q[k][idx_tl + EW'(IMG_W+1)];
    end
  end

  assign last_win = (wr == RW'(HO-1)) && (wc == CW'(WO-1));

  pool_win_reduce #(.DW(DW)) u_red [CH-1:0] (
    .a(win_a), .b(win_b), .c(win_c), .d(win_d), .mode(mode_q), .y(win_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr        <= '0;
      wc        <= '0;
      mode_q    <= POOL_MODE_MAX;
      out_vld_q <= 1'b0;
      frame_q   <= '0;
      pool_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_vld) begin
          frame_q <= bus.conv_lin;
          mode_q  <= bus.mode;
          wr      <= '0;
          wc      <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          for (int k = 0; k < CH; k++) pool_q[k][idx_out] <= win_y[k];
          if (last_win) begin
            wr        <= '0;
            wc        <= '0;
            state     <= ST_DONE;
            out_vld_q <= 1'b1;
          end else if (wc == CW'(WO-1)) begin
            wc <= '0;
            wr <= wr + RW'(1);
          end else begin
            wc <= wc + CW'(1);
          end
        end
        // Handshake returns to IDLE; the next accept is earliest one cycle later.
        ST_DONE: if (bus.out_rdy) begin
          state     <= ST_IDLE;
          out_vld_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_rdy   = (state == ST_IDLE) && !rst;
  assign bus.out_vld  = out_vld_q;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.pool_lin = pool_q;
endmodule

// File: tb/tb_pool_stream_engine.sv
// Directed bench for pool_stream_engine: default geometry plus a 4x8x1x12 instance.
module tb_pool_stream_engine;
  import pool_pkg::*;

  localparam int H = 6, W = 6, C = 3, D = 8;
  localparam int FW = H*W*C*D, PW = (H/2)*(W/2)*C*D;
  localparam int H2 = 4, W2 = 8, C2 = 1, D2 = 12;
  localparam int FW2 = H2*W2*C2*D2, PW2 = (H2/2)*(W2/2)*C2*D2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pool_stream_engine_if #(.IMG_H(H), .IMG_W(W), .CH(C), .DW(D)) bus ();
  pool_stream_engine_if #(.IMG_H(H2), .IMG_W(W2), .CH(C2), .DW(D2)) bus2 ();

  pool_stream_engine #(.IMG_H(H), .IMG_W(W), .CH(C), .DW(D)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  pool_stream_engine #(.IMG_H(H2), .IMG_W(W2), .CH(C2), .DW(D2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  // element (k,r,c) = k*36 + r*6 + c, or 255 minus that when rev
  function automatic logic [FW-1:0] frame_pat(input bit rev);
    logic [FW-1:0] v = '0;
    for (int k = 0; k < C; k++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          int val = k*36 + r*6 + c;
          if (rev) val = 255 - val;
          v[(k*H*W + r*W + c)*D +: D] = D'(val);
        end
    return v;
  endfunction

  // max of each window: bottom-right for the ramp, top-left for the reversed ramp
  function automatic logic [PW-1:0] pool_pat(input bit rev);
    logic [PW-1:0] v = '0;
    for (int k = 0; k < C; k++)
      for (int i = 0; i < H/2; i++)
        for (int j = 0; j < W/2; j++) begin
          int val = rev ? 255 - (k*36 + 2*i*6 + 2*j) : k*36 + (2*i+1)*6 + 2*j + 1;
          v[(k*(H/2)*(W/2) + i*(W/2) + j)*D +: D] = D'(val);
        end
    return v;
  endfunction

  // ch0 windows (0,0)={1,2,3,4}, (0,1)=all 255, (0,2)={0,0,0,3}; rest zero
  function automatic logic [FW-1:0] frame_edge();
    logic [FW-1:0] v = '0;
    v[(0*W+0)*D +: D] = 8'd1;   v[(0*W+1)*D +: D] = 8'd2;
    v[(1*W+0)*D +: D] = 8'd3;   v[(1*W+1)*D +: D] = 8'd4;
    v[(0*W+2)*D +: D] = 8'd255; v[(0*W+3)*D +: D] = 8'd255;
    v[(1*W+2)*D +: D] = 8'd255; v[(1*W+3)*D +: D] = 8'd255;
    v[(1*W+5)*D +: D] = 8'd3;
    return v;
  endfunction

  function automatic logic [PW-1:0] pool_edge(input bit avg);
    logic [PW-1:0] v = '0;
    v[0*D +: D] = avg ? 8'd2 : 8'd4;
    v[1*D +: D] = 8'd255;
    v[2*D +: D] = avg ? 8'd0 : 8'd3;
    return v;
  endfunction

  function automatic logic [FW2-1:0] frame2();
    logic [FW2-1:0] v = '0;
    for (int r = 0; r < H2; r++)
      for (int c = 0; c < W2; c++) v[(r*W2 + c)*D2 +: D2] = D2'(r*8 + c);
    return v;
  endfunction

  function automatic logic [PW2-1:0] pool2();
    logic [PW2-1:0] v = '0;
    for (int i = 0; i < H2/2; i++)
      for (int j = 0; j < W2/2; j++) v[(i*(W2/2) + j)*D2 +: D2] = D2'((2*i+1)*8 + 2*j + 1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accept a frame and wait for out_vld; lat counts edges from the accept cycle.
  task automatic run_frame(input logic [FW-1:0] frm, input logic md, output int lat);
    bus.conv_lin = frm;
    bus.mode     = md;
    bus.in_vld   = 1'b1;
    tick();
    bus.in_vld = 1'b0;
    lat = 1;
    while (!bus.out_vld && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_vld = 1'b0; bus.mode = 1'b0; bus.conv_lin = '0; bus.out_rdy = 1'b0;
    bus2.in_vld = 1'b0; bus2.mode = 1'b0; bus2.conv_lin = '0; bus2.out_rdy = 1'b0;
    tick();
    checks++;
    if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy_held got %b exp 0", bus.in_rdy); end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_vld !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_vld_busy got %b%b exp 00", bus.out_vld, bus.busy);
    end
    checks++;
    if (bus.pool_lin !== '0) begin errors++; $display("FAIL rst_pool got %h exp 0", bus.pool_lin); end
    checks++;
    if (bus.in_rdy !== 1'b1 || bus2.in_rdy !== 1'b1) begin
      errors++; $display("FAIL rst_in_rdy got %b%b exp 11", bus.in_rdy, bus2.in_rdy);
    end
  endtask

  task automatic test_max_latency();
    int lat;
    bus.conv_lin = frame_pat(1'b0);
    bus.mode     = POOL_MODE_MAX;
    bus.in_vld   = 1'b1;
    tick();
    bus.in_vld   = 1'b0;
    bus.conv_lin = '1;
    bus.mode     = POOL_MODE_AVG;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_rdy !== 1'b0) begin
      errors++; $display("FAIL run_busy got busy=%b rdy=%b exp 1 0", bus.busy, bus.in_rdy);
    end
    lat = 1;
    while (!bus.out_vld && lat < 40) begin tick(); lat++; end
    checks++;
    if (lat != 10) begin errors++; $display("FAIL max_latency got %0d exp 10", lat); end
    checks++;
    if (bus.pool_lin !== pool_pat(1'b0)) begin
      errors++; $display("FAIL max_result got %h exp %h", bus.pool_lin, pool_pat(1'b0));
    end
    handshake();
    checks++;
    if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
      errors++; $display("FAIL post_hs got vld=%b rdy=%b exp 0 1", bus.out_vld, bus.in_rdy);
    end
    checks++;
    if (bus.pool_lin !== pool_pat(1'b0)) begin
      errors++; $display("FAIL pool_retain got %h exp %h", bus.pool_lin, pool_pat(1'b0));
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_frame(frame_pat(1'b1), POOL_MODE_MAX, lat);
    checks++;
    if (lat != 10) begin errors++; $display("FAIL bp_latency got %0d exp 10", lat); end
    for (int i = 0; i < 5; i++) begin
      bus.in_vld   = (i % 2 == 0);
      bus.conv_lin = frame_pat(1'b0);
      tick();
      checks++;
      if (bus.out_vld !== 1'b1 || bus.in_rdy !== 1'b0 || bus.pool_lin !== pool_pat(1'b1)) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got vld=%b rdy=%b pool=%h exp 1 0 %h",
                 i, bus.out_vld, bus.in_rdy, bus.pool_lin, pool_pat(1'b1));
      end
    end
    bus.in_vld  = 1'b1;
    bus.out_rdy = 1'b1;
    tick();
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_rdy !== 1'b1) begin
      errors++; $display("FAIL hs_no_accept got busy=%b rdy=%b exp 0 1", bus.busy, bus.in_rdy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus.conv_lin = frame_pat(1'b1);
    bus.mode     = POOL_MODE_MAX;
    bus.in_vld   = 1'b1;
    tick();
    bus.in_vld = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got vld=%b rdy=%b busy=%b exp 0 1 0",
                         bus.out_vld, bus.in_rdy, bus.busy);
    end
    checks++;
    if (bus.pool_lin !== '0) begin errors++; $display("FAIL midrst_pool got %h exp 0", bus.pool_lin); end
    run_frame(frame_pat(1'b0), POOL_MODE_MAX, lat);
    checks++;
    if (lat != 10 || bus.pool_lin !== pool_pat(1'b0)) begin
      errors++; $display("FAIL midrst_next got lat=%0d pool=%h exp 10 %h", lat, bus.pool_lin, pool_pat(1'b0));
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int acc_cyc[3];
    int nacc = 0, nres = 0, cyc = 0;
    bus.mode    = POOL_MODE_MAX;
    bus.out_rdy = 1'b1;
    bus.in_vld  = 1'b1;
    while (nres < 3 && cyc < 100) begin
      if (bus.out_vld) begin
        checks++;
        if (bus.pool_lin !== pool_pat(nres[0])) begin
          errors++; $display("FAIL b2b_result %0d got %h exp %h", nres, bus.pool_lin, pool_pat(nres[0]));
        end
        nres++;
      end
      if (nres < 3 && bus.in_rdy) begin
        if (nacc < 3) begin
          acc_cyc[nacc] = cyc;
          bus.conv_lin  = frame_pat(nacc[0]);
          nacc++;
        end else bus.in_vld = 1'b0;
      end
      if (nres < 3) begin tick(); cyc++; end
    end
    bus.in_vld = 1'b0;
    tick();
    bus.out_rdy = 1'b0;
    checks++;
    if (nres != 3 || nacc != 3) begin
      errors++; $display("FAIL b2b_count got res=%0d acc=%0d exp 3 3", nres, nacc);
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 11 || acc_cyc[2] - acc_cyc[1] != 11) begin
        errors++; $display("FAIL b2b_period got %0d %0d exp 11 11",
                           acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

`ifdef POOL_AVG_EN
  task automatic test_avg();
    int lat;
    run_frame(frame_edge(), POOL_MODE_AVG, lat);
    checks++;
    if (bus.pool_lin !== pool_edge(1'b1)) begin
      errors++; $display("FAIL avg_result got %h exp %h", bus.pool_lin, pool_edge(1'b1));
    end
    handshake();
    run_frame(frame_edge(), POOL_MODE_MAX, lat);
    checks++;
    if (bus.pool_lin !== pool_edge(1'b0)) begin
      errors++; $display("FAIL avgbuild_max got %h exp %h", bus.pool_lin, pool_edge(1'b0));
    end
    handshake();
  endtask
`else
  task automatic test_mode_ignored();
    int lat;
    run_frame(frame_edge(), POOL_MODE_AVG, lat);
    checks++;
    if (bus.pool_lin !== pool_edge(1'b0)) begin
      errors++; $display("FAIL mode1_edge got %h exp %h", bus.pool_lin, pool_edge(1'b0));
    end
    handshake();
    run_frame(frame_pat(1'b0), POOL_MODE_AVG, lat);
    checks++;
    if (bus.pool_lin !== pool_pat(1'b0)) begin
      errors++; $display("FAIL mode1_ramp got %h exp %h", bus.pool_lin, pool_pat(1'b0));
    end
    handshake();
  endtask
`endif

  task automatic test_alt_geometry();
    int lat;
    bus2.conv_lin = frame2();
    bus2.mode     = POOL_MODE_MAX;
    bus2.in_vld   = 1'b1;
    tick();
    bus2.in_vld   = 1'b0;
    bus2.conv_lin = '0;
    lat = 1;
    while (!bus2.out_vld && lat < 40) begin tick(); lat++; end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL alt_latency got %0d exp 9", lat); end
    checks++;
    if (bus2.pool_lin !== pool2()) begin
      errors++; $display("FAIL alt_result got %h exp %h", bus2.pool_lin, pool2());
    end
    bus2.out_rdy = 1'b1;
    tick();
    bus2.out_rdy = 1'b0;
    checks++;
    if (bus2.out_vld !== 1'b0 || bus2.in_rdy !== 1'b1) begin
      errors++; $display("FAIL alt_hs got vld=%b rdy=%b exp 0 1", bus2.out_vld, bus2.in_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_max_latency();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef POOL_AVG_EN
    test_avg();
`else
    test_mode_ignored();
`endif
    test_alt_geometry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
